// File: rtl/audio_synth_wb.sv
// audio_synth_wb: Wishbone-controlled multi-channel tone generator feeding spdif_tx.
//
// Each channel owns a phase accumulator, a waveform select (square/saw/triangle/noise)
// and an 8-bit volume. On every encoder request (out_ack) the channels are mixed one
// per cycle into a wide signed accumulator, saturated to 16 bits and presented
// left-aligned on out_val, which then stays stable until the next request completes.
//
// Ports:
//   clk, rst_n     clk_1x domain clock, asynchronous active-low reset
//   wb_addr        register word address
//   wb_wdata       write data
//   wb_rdata       read data, valid with wb_ack, 0 otherwise
//   wb_we          write strobe
//   wb_cyc         cycle select, held until wb_ack
//   wb_ack         single-cycle acknowledge
//   out_val        current signed sample (16-bit mix left-aligned, LSBs zero)
//   out_ack        encoder consumed out_val, request next sample
//   busy           mix in progress
//
// Sample FSM:
//   state  | meaning
//   S_IDLE | out_val held; waiting for out_ack
//   S_MIX  | accumulating one channel per cycle, idx = channel being processed
//   S_DONE | saturate and publish, step LFSR, bump sample counter

module audio_synth_wb #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_wdata,
    output logic [31:0]      wb_rdata,
    input  logic             wb_we,
    input  logic             wb_cyc,
    output logic             wb_ack,
    output logic [OUT_W-1:0] out_val,
    input  logic             out_ack,
    output logic             busy
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    // Worst case N_CH full-scale contributions can never wrap this accumulator.
    localparam int ACC_W = 16 + $clog2(N_CH) + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIX  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                     global_en;
    logic                     overrun;
    logic [15:0]              sample_cnt;
    logic [15:0]              lfsr;
    logic [PHASE_W-1:0]       phase_inc [N_CH];
    logic [PHASE_W-1:0]       phase     [N_CH];
    logic [1:0]               ch_mode   [N_CH];
    logic [7:0]               ch_vol    [N_CH];
    logic [N_CH-1:0]          ch_en;
    logic [N_CH-1:0]          phase_rst_pend;
    logic [N_CH-1:0]          pend_set;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;

    logic start, mix_step, done, idle_off, idx_last, overrun_set;

    // ------------------------------------------------------------------
    // Sample FSM
    // ------------------------------------------------------------------
    assign idx_last    = (int'(idx) == N_CH - 1);
    assign overrun_set = out_ack & busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        mix_step  = 1'b0;
        done      = 1'b0;
        idle_off  = 1'b0;
        case (state)
            S_IDLE: begin
                if (out_ack) begin
                    if (global_en) begin
                        start     = 1'b1;
                        state_nxt = S_MIX;
                    end else begin
                        idle_off  = 1'b1;
                    end
                end
            end
            S_MIX: begin
                mix_step = 1'b1;
                if (idx_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Wishbone register file
    // ------------------------------------------------------------------
    logic [4:0]  rel;
    logic        ch_hit;
    logic        wb_wr;
    logic        ack_set;
    logic [31:0] rd_val;

    // Ack follows the first cycle of wb_cyc; the ~wb_ack term forces a gap
    // between consecutive acks even if the master keeps wb_cyc high.
    assign ack_set = wb_cyc & ~wb_ack;
    assign wb_wr   = ack_set & wb_we;

    always_comb begin
        rel      = wb_addr - 5'd2;
        ch_hit   = (wb_addr >= 5'd2) && (int'(rel[4:1]) < N_CH);
        rd_val   = '0;
        pend_set = '0;
        if (wb_addr == 5'd0) begin
            rd_val = {31'd0, global_en};
        end else if (wb_addr == 5'd1) begin
            rd_val = {sample_cnt, 14'd0, overrun, busy};
        end else if (ch_hit) begin
            for (int k = 0; k < N_CH; k++) begin
                if (int'(rel[4:1]) == k) begin
                    if (rel[0]) rd_val = {16'd0, ch_vol[k], 5'd0, ch_mode[k], ch_en[k]};
                    else        rd_val = 32'(phase_inc[k]);
                    if (wb_wr && rel[0] && wb_wdata[31]) pend_set[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack    <= 1'b0;
            wb_rdata  <= '0;
            global_en <= 1'b0;
            overrun   <= 1'b0;
            ch_en     <= '0;
            for (int k = 0; k < N_CH; k++) begin
                phase_inc[k] <= '0;
                ch_mode[k]   <= '0;
                ch_vol[k]    <= '0;
            end
        end else begin
            wb_ack   <= ack_set;
            wb_rdata <= ack_set ? rd_val : '0;

            // A new overrun in the same cycle as the clear keeps the flag set.
            if (overrun_set)
                overrun <= 1'b1;
            else if (wb_wr && wb_addr == 5'd1 && wb_wdata[1])
                overrun <= 1'b0;

            if (wb_wr) begin
                if (wb_addr == 5'd0) global_en <= wb_wdata[0];
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_hit && int'(rel[4:1]) == k) begin
                        if (rel[0]) begin
                            ch_en[k]   <= wb_wdata[0];
                            ch_mode[k] <= wb_wdata[2:1];
                            ch_vol[k]  <= wb_wdata[15:8];
                        end else begin
                            phase_inc[k] <= PHASE_W'(wb_wdata);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel datapath (channel idx during S_MIX)
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0]      cur_phase, cur_inc;
    logic [1:0]              cur_mode;
    logic [7:0]              cur_vol;
    logic                    cur_en;
    logic [15:0]             u, w;
    logic signed [24:0]      w_ext, vol_ext, prod;
    logic signed [16:0]      contrib;
    logic signed [ACC_W-1:0] contrib_ext;
    logic [15:0]             sat16;
    logic [OUT_W-1:0]        out_nxt;

    always_comb begin
        cur_phase = '0;
        cur_inc   = '0;
        cur_mode  = '0;
        cur_vol   = '0;
        cur_en    = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) begin
                cur_phase = phase[k];
                cur_inc   = phase_inc[k];
                cur_mode  = ch_mode[k];
                cur_vol   = ch_vol[k];
                cur_en    = ch_en[k];
            end
        end

        u = cur_phase[PHASE_W-1 -: 16];
        case (cur_mode)
            2'd0:    w = u[15] ? 16'h8000 : 16'h7FFF;
            2'd1:    w = u ^ 16'h8000;
            2'd2:    w = {(u[15] ? ~u[14:0] : u[14:0]), 1'b0} ^ 16'h8000;
            default: w = lfsr;
        endcase

        // Signed waveform times unsigned volume; >>> 8 gives floor division.
        w_ext       = 25'($signed(w));
        vol_ext     = $signed({17'd0, cur_vol});
        prod        = w_ext * vol_ext;
        contrib     = cur_en ? 17'(prod >>> 8) : '0;
        contrib_ext = ACC_W'(contrib);

        if (acc > SAT_HI)      sat16 = 16'h7FFF;
        else if (acc < SAT_LO) sat16 = 16'h8000;
        else                   sat16 = acc[15:0];

        out_nxt = '0;
        out_nxt[OUT_W-1 -: 16] = sat16;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            idx            <= '0;
            acc            <= '0;
            out_val        <= '0;
            lfsr           <= 16'hACE1;
            sample_cnt     <= '0;
            phase_rst_pend <= '0;
            for (int k = 0; k < N_CH; k++) phase[k] <= '0;
        end else begin
            if (start) begin
                busy <= 1'b1;
                idx  <= '0;
                acc  <= '0;
            end
            if (mix_step) begin
                acc <= acc + contrib_ext;
                idx <= idx + IDX_W'(1);
            end
            if (done) begin
                out_val    <= out_nxt;
                lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                sample_cnt <= sample_cnt + 16'd1;
                busy       <= 1'b0;
            end
            if (idle_off) out_val <= '0;

            // Pending phase resets are consumed when a sample starts, so the
            // zeroed phase is what the mix sees for that channel.
            phase_rst_pend <= (phase_rst_pend & ~{N_CH{start}}) | pend_set;
            for (int k = 0; k < N_CH; k++) begin
                if (start && phase_rst_pend[k])
                    phase[k] <= '0;
                else if (mix_step && int'(idx) == k)
                    phase[k] <= cur_en ? cur_phase + cur_inc : '0;
            end
        end
    end

endmodule

// File: tb/tb_audio_synth_wb.sv
// Directed bench for audio_synth_wb (N_CH=4, PHASE_W=24, OUT_W=24).
module tb_audio_synth_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [31:0] wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic [23:0] out_val;
    logic        out_ack = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    audio_synth_wb #(.N_CH(4), .PHASE_W(24), .OUT_W(24)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_addr (wb_addr),
        .wb_wdata(wb_wdata),
        .wb_rdata(wb_rdata),
        .wb_we   (wb_we),
        .wb_cyc  (wb_cyc),
        .wb_ack  (wb_ack),
        .out_val (out_val),
        .out_ack (out_ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic [4:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        bit got;
        got = 1'b0;
        rd = '0;
        lat = 0;
        wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
        while (!got && lat < 10) begin
            tick();
            lat++;
            if (wb_ack) begin
                got = 1'b1;
                rd = wb_rdata;
            end
        end
        if (!got) lat = -1;
        wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0;
        tick();
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        wb_xfer(a, 1'b1, d, rd, lat);
    endtask

    task automatic take_sample(output logic signed [15:0] v, output int lat);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        lat = 0;
        while (busy && lat < 50) begin
            tick();
            lat++;
        end
        v = out_val[23:8];
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int addrs[5] = '{0, 1, 2, 3, 30};
        logic [31:0] rd;
        int lat;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL rst_wb_ack got %0b exp 0", wb_ack); end
        checks++; if (wb_rdata !== 32'h0) begin failures++; $display("FAIL rst_wb_rdata got %h exp 0", wb_rdata); end
        checks++; if (out_val !== 24'h0) begin failures++; $display("FAIL rst_out_val got %h exp 0", out_val); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %0b exp 0", busy); end
        rst_n = 1'b1;
        tick();
        foreach (addrs[i]) begin
            wb_xfer(5'(addrs[i]), 1'b0, 32'h0, rd, lat);
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_read[%0d] got %h exp 0", addrs[i], rd); end
            checks++; if (lat !== 1) begin failures++; $display("FAIL rst_read_lat[%0d] got %0d exp 1", addrs[i], lat); end
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        logic signed [15:0] v;
        int lat;
        wb_write(5'd4, 32'hFFFF_FFFF);
        wb_xfer(5'd4, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h00FF_FFFF) begin failures++; $display("FAIL inc1_readback got %h exp 00ffffff", rd); end
        wb_write(5'd5, 32'h8000_FF07);
        wb_xfer(5'd5, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0000_FF07) begin failures++; $display("FAIL ctrl1_readback got %h exp 0000ff07", rd); end
        wb_write(5'd10, 32'hFFFF_FFFF);
        wb_xfer(5'd10, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_readback got %h exp 0", rd); end
        wb_write(5'd5, 32'h0);
        wb_write(5'd4, 32'h0);
        // GLOBAL.enable is 0: a request must not start a mix
        take_sample(v, lat);
        checks++; if (lat !== 0) begin failures++; $display("FAIL disabled_busy_cycles got %0d exp 0", lat); end
        checks++; if (out_val !== 24'h0) begin failures++; $display("FAIL disabled_out_val got %h exp 0", out_val); end
        wb_xfer(5'd1, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL disabled_status got %h exp 0", rd); end
    endtask

    task automatic test_square();
        int exp_v[4] = '{32639, 32639, -32640, -32640};
        logic signed [15:0] v;
        int lat;
        wb_write(5'd2, 32'h0040_0000);
        wb_write(5'd3, 32'h0000_FF01);
        wb_write(5'd0, 32'h1);
        for (int i = 0; i < 4; i++) begin
            take_sample(v, lat);
            checks++; if (v !== 16'(exp_v[i])) begin failures++; $display("FAIL sq_val[%0d] got %0d exp %0d", i, v, exp_v[i]); end
            checks++; if (lat !== 5) begin failures++; $display("FAIL sq_latency[%0d] got %0d exp 5", i, lat); end
            checks++; if (out_val[7:0] !== 8'h0) begin failures++; $display("FAIL sq_lsb[%0d] got %h exp 0", i, out_val[7:0]); end
            repeat (94) tick();
            checks++; if ($signed(out_val[23:8]) !== exp_v[i]) begin failures++; $display("FAIL sq_stable[%0d] got %0d exp %0d", i, $signed(out_val[23:8]), exp_v[i]); end
        end
    endtask

    task automatic test_saturation();
        int exp_v[4] = '{32767, 32767, -32768, -32768};
        logic signed [15:0] v;
        int lat;
        wb_write(5'd3, 32'h8000_FF01);
        for (int c = 1; c < 4; c++) begin
            wb_write(5'(2 + 2 * c), 32'h0040_0000);
            wb_write(5'(3 + 2 * c), 32'h8000_FF01);
        end
        for (int i = 0; i < 4; i++) begin
            take_sample(v, lat);
            checks++; if (v !== 16'(exp_v[i])) begin failures++; $display("FAIL sat_val[%0d] got %0d exp %0d", i, v, exp_v[i]); end
        end
    endtask

    task automatic test_saw();
        logic signed [15:0] s[65];
        logic signed [15:0] v;
        int lat;
        bit rising;
        for (int c = 1; c < 4; c++) wb_write(5'(3 + 2 * c), 32'h0);
        wb_write(5'd2, 32'h0004_0000);
        wb_write(5'd3, 32'h8000_FF03);
        for (int i = 0; i < 65; i++) begin
            take_sample(v, lat);
            s[i] = v;
        end
        checks++; if (s[0] !== -16'sd32640) begin failures++; $display("FAIL saw_first got %0d exp -32640", s[0]); end
        checks++; if (s[32] !== 16'sd0) begin failures++; $display("FAIL saw_mid got %0d exp 0", s[32]); end
        checks++; if (s[63] !== 16'sd31620) begin failures++; $display("FAIL saw_last got %0d exp 31620", s[63]); end
        checks++; if (s[64] !== -16'sd32640) begin failures++; $display("FAIL saw_wrap got %0d exp -32640", s[64]); end
        rising = 1'b1;
        for (int i = 1; i < 64; i++) if (s[i] <= s[i-1]) rising = 1'b0;
        checks++; if (rising !== 1'b1) begin failures++; $display("FAIL saw_rising got %0b exp 1", rising); end
    endtask

    task automatic test_reset_mid_mix();
        logic [31:0] rd;
        int lat;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got %0b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %0b exp 0", busy); end
        checks++; if (out_val !== 24'h0) begin failures++; $display("FAIL midrst_out_val got %h exp 0", out_val); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wb_xfer(5'd1, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midrst_status got %h exp 0", rd); end
        wb_xfer(5'd3, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midrst_ctrl0 got %h exp 0", rd); end
    endtask

    task automatic test_noise();
        logic signed [15:0] v;
        int lat;
        wb_write(5'd3, 32'h0000_FF07);
        wb_write(5'd0, 32'h1);
        // 0xACE1 = -21279; -21279*255/256 floors to -21196
        take_sample(v, lat);
        checks++; if (v !== -16'sd21196) begin failures++; $display("FAIL noise_first got %0d exp -21196", v); end
        // LFSR after one step is 0x5670 = 22128; 22128*255/256 floors to 22041
        take_sample(v, lat);
        checks++; if (v !== 16'sd22041) begin failures++; $display("FAIL noise_second got %0d exp 22041", v); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        int lat;
        int waited;
        apply_reset();
        wb_write(5'd2, 32'h0040_0000);
        wb_write(5'd3, 32'h0000_FF01);
        wb_write(5'd0, 32'h1);
        out_ack = 1'b1; tick();
        out_ack = 1'b0; tick();
        out_ack = 1'b1; tick();
        out_ack = 1'b0;
        wb_xfer(5'd1, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0000_0003) begin failures++; $display("FAIL ovr_status_mix got %h exp 00000003", rd); end
        waited = 0;
        while (busy && waited < 50) begin tick(); waited++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_busy_end got %0b exp 0", busy); end
        repeat (10) tick();
        wb_xfer(5'd1, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0001_0002) begin failures++; $display("FAIL ovr_status_done got %h exp 00010002", rd); end
        checks++; if ($signed(out_val[23:8]) !== 32639) begin failures++; $display("FAIL ovr_out_val got %0d exp 32639", $signed(out_val[23:8])); end
        wb_write(5'd1, 32'h2);
        wb_xfer(5'd1, 1'b0, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL ovr_status_clr got %h exp 00010000", rd); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_square();
        test_saturation();
        test_saw();
        test_reset_mid_mix();
        test_noise();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
